// File: rtl/shift_word_tx.sv
// Front-panel serial word transmitter: loads a switch word, shifts it out MSB-first
// one bit per key press, appends even parity, and counts completed words on 7-seg displays.
module shift_word_tx #(
  parameter int W  = 10,
  parameter int CW = 8
) (
  input  logic          CLOCK_50,
  input  logic          INV_KEY_1,
  input  logic [W-1:0]  data_in,
  input  logic          load,
  input  logic          step,
  output logic          tx_bit,
  output logic          busy,
  output logic          done,
  output logic [3:0]    bit_idx,
  output logic [W-1:0]  LEDR,
  output logic [CW-1:0] tx_count,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX2
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PARITY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          tx_bit_q, tx_bit_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] tx_count_q, tx_count_d;
  logic [2:0]    step_sync_q, step_sync_d;
  logic [2:0]    load_sync_q, load_sync_d;
  logic [6:0]    hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic          step_rise, load_rise;
  logic [CW-1:0] dig_ones, dig_tens, dig_hund;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    // Keys are asynchronous: two flops to synchronise, third as edge history.
    step_sync_d = {step_sync_q[1:0], step};
    load_sync_d = {load_sync_q[1:0], load};
    step_rise   = step_sync_q[1] & ~step_sync_q[2];
    load_rise   = load_sync_q[1] & ~load_sync_q[2];

    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    parity_d   = parity_q;
    tx_count_d = tx_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A simultaneous step edge is simply dropped here: load has priority.
        if (load_rise) begin
          shreg_d   = data_in;
          parity_d  = ^data_in;
          bit_idx_d = 4'd0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (step_rise) begin
          shreg_d   = {shreg_q[W-2:0], 1'b0};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(W-1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (step_rise) begin
          state_d    = S_DONE;
          tx_count_d = tx_count_q + CW'(1);
          bit_idx_d  = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The shift register is empty once all data bits are out, so DONE/IDLE present 0.
    tx_bit_d = (state_d == S_PARITY) ? parity_d : shreg_d[W-1];

    dig_hund = tx_count_q / CW'(100);
    dig_tens = (tx_count_q / CW'(10)) % CW'(10);
    dig_ones = tx_count_q % CW'(10);
    hex2_d   = seg7(dig_hund[3:0]);
    hex1_d   = seg7(dig_tens[3:0]);
    hex0_d   = seg7(dig_ones[3:0]);
  end

  always_ff @(posedge CLOCK_50 or posedge INV_KEY_1) begin
    if (INV_KEY_1) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      tx_bit_q    <= 1'b0;
      parity_q    <= 1'b0;
      tx_count_q  <= '0;
      step_sync_q <= 3'b000;
      load_sync_q <= 3'b000;
      hex0_q      <= 7'b1000000;
      hex1_q      <= 7'b1000000;
      hex2_q      <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      tx_bit_q    <= tx_bit_d;
      parity_q    <= parity_d;
      tx_count_q  <= tx_count_d;
      step_sync_q <= step_sync_d;
      load_sync_q <= load_sync_d;
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign busy     = (state_q == S_SEND) || (state_q == S_PARITY);
  assign done     = (state_q == S_DONE);
  assign bit_idx  = bit_idx_q;
  assign LEDR     = shreg_q;
  assign tx_count = tx_count_q;
  assign HEX0     = hex0_q;
  assign HEX1     = hex1_q;
  assign HEX2     = hex2_q;

endmodule

// File: tb/tb_shift_word_tx.sv
// Self-checking bench for shift_word_tx: expected serial streams, counts and digits
// are derived from the word value and a running word tally.
module tb_shift_word_tx;
  localparam int W  = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          load, step;
  logic          tx_bit, busy, done;
  logic [3:0]    bit_idx;
  logic [W-1:0]  ledr;
  logic [CW-1:0] tx_count;
  logic [6:0]    hex0, hex1, hex2;

  int checks = 0;
  int errors = 0;
  int words  = 0;

  always #5 clk = ~clk;

  shift_word_tx #(.W(W), .CW(CW)) dut (
    .CLOCK_50(clk), .INV_KEY_1(rst), .data_in(data_in), .load(load), .step(step),
    .tx_bit(tx_bit), .busy(busy), .done(done), .bit_idx(bit_idx), .LEDR(ledr),
    .tx_count(tx_count), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected serial bit i of word d: data MSB-first, then even parity.
  function automatic logic exp_bit(input logic [W-1:0] d, input int i);
    int ones = 0;
    if (i < W) return d[W-1-i];
    for (int k = 0; k < W; k++) ones += d[k];
    return logic'(ones % 2);
  endfunction

  task automatic press(input logic do_load, input logic do_step, input int hold);
    @(negedge clk);
    load = do_load;
    step = do_step;
    repeat (hold) @(negedge clk);
    load = 1'b0;
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_word(input logic [W-1:0] d);
    data_in = d;
    press(1'b1, 1'b0, 3);
    for (int i = 0; i <= W; i++) press(1'b0, 1'b1, 3);
    words++;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; step = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_bit !== 1'b0 || bit_idx !== 4'd0 ||
        ledr !== '0 || tx_count !== '0 || hex0 !== 7'b1000000 ||
        hex1 !== 7'b1000000 || hex2 !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b tx=%b idx=%0d ledr=%h cnt=%0d hex=%b/%b/%b required idle zeros, hex 1000000",
               busy, done, tx_bit, bit_idx, ledr, tx_count, hex2, hex1, hex0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_word;
    for (int n = 0; n < 5; n++) run_word(W'($urandom));
    checks++;
    if (tx_count !== 8'd5) begin
      errors++;
      $display("FAIL count_before_reset: got %0d required 5", tx_count);
    end
    data_in = 10'b1111111111;
    press(1'b1, 1'b0, 3);
    repeat (3) press(1'b0, 1'b1, 3);
    checks++;
    if (busy !== 1'b1 || bit_idx !== 4'd3) begin
      errors++;
      $display("FAIL mid_word_setup: got busy=%b idx=%0d required busy=1 idx=3", busy, bit_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_bit !== 1'b0 || tx_count !== '0 || ledr !== '0 ||
        bit_idx !== 4'd0 || hex0 !== 7'b1000000 || hex1 !== 7'b1000000 || hex2 !== 7'b1000000) begin
      errors++;
      $display("FAIL async_reset: got busy=%b tx=%b cnt=%0d ledr=%h idx=%0d hex=%b/%b/%b required all cleared",
               busy, tx_bit, tx_count, ledr, bit_idx, hex2, hex1, hex0);
    end
    words = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous;
    logic [W-1:0] d;
    d = W'($urandom);
    data_in = d;
    press(1'b1, 1'b1, 3);
    checks++;
    if (busy !== 1'b1 || bit_idx !== 4'd0 || tx_bit !== d[W-1] || ledr !== d) begin
      errors++;
      $display("FAIL load_step_same_cycle: got busy=%b idx=%0d tx=%b ledr=%h required 1/0/%b/%h",
               busy, bit_idx, tx_bit, ledr, d[W-1], d);
    end
    for (int i = 0; i <= W; i++) press(1'b0, 1'b1, 3);
    words++;
  endtask

  task automatic test_word(input logic [W-1:0] d, input string name);
    data_in = d;
    press(1'b1, 1'b0, 3);
    for (int i = 0; i <= W; i++) begin
      checks++;
      if (tx_bit !== exp_bit(d, i) || bit_idx !== 4'(i) || busy !== 1'b1 ||
          (i < W && ledr !== W'(d << i))) begin
        errors++;
        $display("FAIL %s_bit%0d: got tx=%b idx=%0d busy=%b ledr=%h required tx=%b idx=%0d busy=1 ledr=%h",
                 name, i, tx_bit, bit_idx, busy, ledr, exp_bit(d, i), i, W'(d << i));
      end
      press(1'b0, 1'b1, 3);
    end
    words++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_bit !== 1'b0 || tx_count !== CW'(words % 256) ||
        hex0 !== seg_of((words % 256) % 10) || hex1 !== seg_of(((words % 256) / 10) % 10) ||
        hex2 !== seg_of((words % 256) / 100)) begin
      errors++;
      $display("FAIL %s_end: got done=%b busy=%b tx=%b cnt=%0d hex=%b/%b/%b required done=1 busy=0 tx=0 cnt=%0d",
               name, done, busy, tx_bit, tx_count, hex2, hex1, hex0, words % 256);
    end
    $display("word %0d %s data=%h parity=%b", words, name, d, exp_bit(d, W));
  endtask

  task automatic test_ignored_load;
    logic [W-1:0] a;
    a = 10'b1100101011;
    data_in = a;
    press(1'b1, 1'b0, 3);
    repeat (4) press(1'b0, 1'b1, 3);
    data_in = ~a;
    press(1'b1, 1'b0, 3);
    checks++;
    if (bit_idx !== 4'd4 || ledr !== W'(a << 4) || tx_bit !== exp_bit(a, 4)) begin
      errors++;
      $display("FAIL load_during_send: got idx=%0d ledr=%h tx=%b required idx=4 ledr=%h tx=%b",
               bit_idx, ledr, tx_bit, W'(a << 4), exp_bit(a, 4));
    end
    for (int i = 4; i <= W; i++) begin
      checks++;
      if (tx_bit !== exp_bit(a, i) || bit_idx !== 4'(i)) begin
        errors++;
        $display("FAIL after_ignored_load_bit%0d: got tx=%b idx=%0d required tx=%b idx=%0d",
                 i, tx_bit, bit_idx, exp_bit(a, i), i);
      end
      press(1'b0, 1'b1, 3);
    end
    words++;
  endtask

  task automatic test_held_step;
    logic [W-1:0] d;
    d = W'($urandom);
    data_in = d;
    press(1'b1, 1'b0, 3);
    press(1'b0, 1'b1, 50);
    checks++;
    if (bit_idx !== 4'd1 || tx_bit !== d[W-2]) begin
      errors++;
      $display("FAIL held_step: got idx=%0d tx=%b required idx=1 tx=%b", bit_idx, tx_bit, d[W-2]);
    end
    for (int i = 1; i <= W; i++) press(1'b0, 1'b1, 3);
    words++;
  endtask

  task automatic test_step_in_done;
    press(1'b0, 1'b1, 3);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bit_idx !== 4'd0 || tx_bit !== 1'b0 ||
        tx_count !== CW'(words % 256)) begin
      errors++;
      $display("FAIL step_in_done: got done=%b idx=%0d tx=%b cnt=%0d required done=1 idx=0 tx=0 cnt=%0d",
               done, bit_idx, tx_bit, tx_count, words % 256);
    end
  endtask

  task automatic test_count_display;
    while (words < 123) run_word(W'($urandom));
    checks++;
    if (tx_count !== 8'd123 || hex2 !== 7'b1111001 || hex1 !== 7'b0100100 || hex0 !== 7'b0110000) begin
      errors++;
      $display("FAIL display_123: got cnt=%0d hex=%b/%b/%b required 123 1111001/0100100/0110000",
               tx_count, hex2, hex1, hex0);
    end
    while (words < 256) run_word(W'($urandom));
    checks++;
    if (tx_count !== 8'd0 || hex2 !== 7'b1000000 || hex1 !== 7'b1000000 || hex0 !== 7'b1000000) begin
      errors++;
      $display("FAIL display_wrap: got cnt=%0d hex=%b/%b/%b required 0 all 1000000",
               tx_count, hex2, hex1, hex0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_word();
    test_simultaneous();
    test_word(10'b1011001110, "basic");
    test_word(10'h001, "odd_weight");
    test_ignored_load();
    test_held_step();
    test_step_in_done();
    for (int n = 0; n < 6; n++) test_word(W'($urandom), "random");
    test_count_display();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
